// File: rtl/cyclic_queue_pkg.sv
// Shared constants for the cyclic replay queue and the accelerator controller.
package cyclic_queue_pkg;

   localparam int unsigned DEFAULT_DATA_W = 32;
   localparam int unsigned DEFAULT_DEPTH  = 64;
   localparam int unsigned DEFAULT_LOOP_W = 8;

   typedef enum logic {
      MODE_CONSUME = 1'b0,
      MODE_CYCLIC  = 1'b1
   } mode_e;

endpackage

// File: rtl/cyclic_queue_ram.sv
// DEPTH x DATA_W storage: synchronous write port, registered read port.
// The read register clears on reset/clr and holds when no read is issued.
module cyclic_queue_ram #(
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned DEPTH  = 64,
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_d, rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Same-address read and write returns the old word (read-before-write).
   always_comb begin
      rd_data_d = rd_data_q;
      if (clr) begin
         rd_data_d = '0;
      end else if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/cyclic_replay_queue.sv
// Queue with FIFO (consume) and non-destructive wrap-around replay (cyclic) modes,
// occupancy flags, pass counter, synchronous flush and sticky error flag.
module cyclic_replay_queue
   import cyclic_queue_pkg::*;
#(
   parameter  int unsigned DATA_W = DEFAULT_DATA_W,
   parameter  int unsigned DEPTH  = DEFAULT_DEPTH,
   parameter  int unsigned LOOP_W = DEFAULT_LOOP_W,
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              cyclic,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd_en,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              wrap,
   output logic [LOOP_W-1:0] loop_cnt,
   output logic [AW:0]       count,
   output logic              full,
   output logic              empty,
   output logic              err
);

   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   mode_e             mode;
   logic [AW-1:0]     head_d, head_q;
   logic [AW-1:0]     tail_d, tail_q;
   logic [AW-1:0]     idx_d, idx_q;
   logic [AW:0]       count_d, count_q;
   logic [LOOP_W-1:0] loop_d, loop_q;
   logic              valid_d, valid_q;
   logic              wrap_d, wrap_q;
   logic              err_d, err_q;
   logic              rd_ok, wr_ok, pop, last;
   logic              ram_we, ram_re;
   logic [AW-1:0]     ram_raddr;

   assign mode  = mode_e'(cyclic);
   assign full  = (count_q == DEPTH_CNT);
   assign empty = (count_q == '0);
   assign count = count_q;

   // A full queue still accepts a write when a consume read frees a slot in the same cycle.
   assign rd_ok = rd_en && !empty;
   assign pop   = rd_ok && (mode == MODE_CONSUME);
   assign wr_ok = wr_en && (!full || pop);
   assign last  = ({1'b0, idx_q} == (count_q - (AW+1)'(1)));

   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      idx_d     = idx_q;
      count_d   = count_q;
      loop_d    = loop_q;
      err_d     = err_q;
      valid_d   = 1'b0;
      wrap_d    = 1'b0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_raddr = head_q;
      if (clear) begin
         head_d  = '0;
         tail_d  = '0;
         idx_d   = '0;
         count_d = '0;
         loop_d  = '0;
         err_d   = 1'b0;
      end else begin
         if (wr_ok) begin
            ram_we = 1'b1;
            tail_d = tail_q + AW'(1);
         end
         if (rd_ok) begin
            ram_re  = 1'b1;
            valid_d = 1'b1;
            if (mode == MODE_CONSUME) begin
               head_d = head_q + AW'(1);
            end else begin
               ram_raddr = head_q + idx_q;
               if (last) begin
                  idx_d  = '0;
                  wrap_d = 1'b1;
                  loop_d = loop_q + LOOP_W'(1);
               end else begin
                  idx_d = idx_q + AW'(1);
               end
            end
         end
         if (mode == MODE_CONSUME) begin
            idx_d = '0;
         end
         unique case ({wr_ok, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
         if ((wr_en && !wr_ok) || (rd_en && empty)) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         idx_q   <= '0;
         count_q <= '0;
         loop_q  <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         loop_q  <= loop_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

   cyclic_queue_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst),
      .clr     (clear),
      .wr_en   (ram_we),
      .wr_addr (tail_q),
      .wr_data (data_in),
      .rd_en   (ram_re),
      .rd_addr (ram_raddr),
      .rd_data (data_out)
   );

   assign data_valid = valid_q;
   assign wrap       = wrap_q;
   assign loop_cnt   = loop_q;
   assign err        = err_q;

endmodule

// File: tb/tb_cyclic_replay_queue.sv
// Self-checking bench for cyclic_replay_queue: vector table plus scoreboarded read sequences.
module tb_cyclic_replay_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        cyclic;
   logic        wr_en;
   logic [31:0] data_in;
   logic        rd_en;
   logic [31:0] data_out;
   logic        data_valid;
   logic        wrap;
   logic [7:0]  loop_cnt;
   logic [6:0]  count;
   logic        full;
   logic        empty;
   logic        err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        clr;
      logic        cyc;
      logic        wr;
      logic [31:0] din;
      logic        rd;
      logic        val;
      logic [31:0] dout;
      logic [6:0]  cnt;
      logic        emp;
      logic        err;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic        w;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   logic sb_on = 1'b0;

   cyclic_replay_queue #(
      .DATA_W (32),
      .DEPTH  (64),
      .LOOP_W (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .cyclic     (cyclic),
      .wr_en      (wr_en),
      .data_in    (data_in),
      .rd_en      (rd_en),
      .data_out   (data_out),
      .data_valid (data_valid),
      .wrap       (wrap),
      .loop_cnt   (loop_cnt),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clear   = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      data_in = '0;
   endtask

   task automatic add_vec(input logic clr, input logic cyc, input logic wr, input logic [31:0] din,
                          input logic rd, input logic val, input logic [31:0] dout,
                          input logic [6:0] cnt, input logic emp, input logic e);
      vec_t v;
      v.clr = clr; v.cyc = cyc; v.wr = wr; v.din = din; v.rd = rd;
      v.val = val; v.dout = dout; v.cnt = cnt; v.emp = emp; v.err = e;
      vecs.push_back(v);
   endtask

   task automatic sb_read(input logic [31:0] d, input logic w);
      exp_t e;
      e.d = d;
      e.w = w;
      sb.push_back(e);
      rd_en = 1'b1;
      step();
   endtask

   task automatic sb_drain(input string name);
      idle();
      repeat (2) @(negedge clk);
      check(name, 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   always @(negedge clk) begin
      if (sb_on && rst && data_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got data_valid=1 data_out=%0h expected no read", data_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_data", 64'(data_out), 64'(e.d));
            check("sb_wrap", 64'(wrap), 64'(e.w));
         end
      end
   end

   initial begin
      rst    = 1'b0;
      cyclic = 1'b0;
      idle();

      // Reset held with random requests
      for (int i = 0; i < 4; i++) begin
         wr_en   = 1'($urandom_range(0, 1));
         rd_en   = 1'($urandom_range(0, 1));
         data_in = $urandom;
         step();
      end
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_full", 64'(full), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_dout", 64'(data_out), 64'd0);
      check("rst_valid", 64'(data_valid), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      idle();
      rst = 1'b1;
      step();
      step();
      check("rel_empty", 64'(empty), 64'd1);
      check("rel_count", 64'(count), 64'd0);
      check("rel_dout", 64'(data_out), 64'd0);
      check("rel_loop", 64'(loop_cnt), 64'd0);
      check("rel_err", 64'(err), 64'd0);

      // Vector table: consume, underflow, empty wr+rd, clear, wr+rd in flight
      //       clr   cyc   wr    din     rd    val   dout    cnt   emp   err
      add_vec(1'b0, 1'b0, 1'b1, 32'h1,  1'b0, 1'b0, 32'h0,  7'd1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b0, 1'b1, 32'h2,  1'b0, 1'b0, 32'h0,  7'd2, 1'b0, 1'b0);
      add_vec(1'b0, 1'b0, 1'b1, 32'h3,  1'b0, 1'b0, 32'h0,  7'd3, 1'b0, 1'b0);
      add_vec(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h1,  7'd2, 1'b0, 1'b0);
      add_vec(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h2,  7'd1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h3,  7'd0, 1'b1, 1'b0);
      add_vec(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h3,  7'd0, 1'b1, 1'b1);
      add_vec(1'b0, 1'b0, 1'b1, 32'h5,  1'b1, 1'b0, 32'h3,  7'd1, 1'b0, 1'b1);
      add_vec(1'b1, 1'b0, 1'b1, 32'h9,  1'b1, 1'b0, 32'h0,  7'd0, 1'b1, 1'b0);
      add_vec(1'b0, 1'b0, 1'b1, 32'h7,  1'b0, 1'b0, 32'h0,  7'd1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b0, 1'b1, 32'h8,  1'b1, 1'b1, 32'h7,  7'd1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h8,  7'd0, 1'b1, 1'b0);
      add_vec(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h8,  7'd0, 1'b1, 1'b1);
      add_vec(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  7'd0, 1'b1, 1'b0);
      foreach (vecs[i]) begin
         clear   = vecs[i].clr;
         cyclic  = vecs[i].cyc;
         wr_en   = vecs[i].wr;
         data_in = vecs[i].din;
         rd_en   = vecs[i].rd;
         step();
         check($sformatf("vec%0d_valid", i), 64'(data_valid), 64'(vecs[i].val));
         check($sformatf("vec%0d_dout", i), 64'(data_out), 64'(vecs[i].dout));
         check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].cnt));
         check($sformatf("vec%0d_empty", i), 64'(empty), 64'(vecs[i].emp));
         check($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].err));
      end
      idle();
      cyclic = 1'b0;

      // Cyclic replay of 12 words for 30 reads
      sb_on = 1'b1;
      for (int i = 0; i < 12; i++) begin
         wr_en   = 1'b1;
         data_in = 32'hA0 + 32'(i);
         step();
      end
      idle();
      cyclic = 1'b1;
      for (int k = 0; k < 30; k++) begin
         sb_read(32'hA0 + 32'(k % 12), (k % 12) == 11);
      end
      sb_drain("replay_drain");
      check("replay_loop", 64'(loop_cnt), 64'd2);
      check("replay_count", 64'(count), 64'd12);

      // Full boundary: drop on full, then wr+rd on full in consume mode
      cyclic = 1'b0;
      clear  = 1'b1;
      step();
      idle();
      for (int i = 0; i < 64; i++) begin
         wr_en   = 1'b1;
         data_in = 32'h100 + 32'(i);
         step();
      end
      check("full_flag", 64'(full), 64'd1);
      check("full_count", 64'(count), 64'd64);
      check("full_err0", 64'(err), 64'd0);
      data_in = 32'hDEAD;
      step();
      check("ovf_err", 64'(err), 64'd1);
      check("ovf_count", 64'(count), 64'd64);
      data_in = 32'h555;
      sb_read(32'h100, 1'b0);
      check("fullrw_count", 64'(count), 64'd64);
      check("fullrw_full", 64'(full), 64'd1);
      wr_en = 1'b0;
      for (int i = 0; i < 64; i++) begin
         sb_read((i < 63) ? 32'h101 + 32'(i) : 32'h555, 1'b0);
      end
      sb_drain("full_drain");
      check("full_empty_after", 64'(empty), 64'd1);

      // Mode switch mid-replay, then clear during replay
      clear = 1'b1;
      step();
      idle();
      for (int i = 0; i < 12; i++) begin
         wr_en   = 1'b1;
         data_in = 32'hA0 + 32'(i);
         step();
      end
      idle();
      cyclic = 1'b1;
      for (int k = 0; k < 5; k++) begin
         sb_read(32'hA0 + 32'(k), 1'b0);
      end
      cyclic = 1'b0;
      sb_read(32'hA0, 1'b0);
      check("switch_count", 64'(count), 64'd11);
      cyclic = 1'b1;
      sb_read(32'hA1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         sb_read(32'hA2 + 32'(k), k == 9);
      end
      sb_drain("switch_drain");
      check("switch_loop", 64'(loop_cnt), 64'd1);
      check("switch_count2", 64'(count), 64'd11);
      sb_on   = 1'b0;
      clear   = 1'b1;
      wr_en   = 1'b1;
      data_in = 32'hBEEF;
      rd_en   = 1'b1;
      step();
      idle();
      check("clr_count", 64'(count), 64'd0);
      check("clr_loop", 64'(loop_cnt), 64'd0);
      check("clr_err", 64'(err), 64'd0);
      check("clr_dout", 64'(data_out), 64'd0);
      check("clr_valid", 64'(data_valid), 64'd0);
      check("clr_empty", 64'(empty), 64'd1);

      // Asynchronous reset between edges
      cyclic  = 1'b0;
      wr_en   = 1'b1;
      data_in = 32'h77;
      step();
      data_in = 32'h78;
      step();
      wr_en = 1'b0;
      rd_en = 1'b1;
      step();
      idle();
      check("pre_rst_dout", 64'(data_out), 64'h77);
      check("pre_rst_count", 64'(count), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      check("arst_dout", 64'(data_out), 64'd0);
      check("arst_valid", 64'(data_valid), 64'd0);
      check("arst_count", 64'(count), 64'd0);
      check("arst_empty", 64'(empty), 64'd1);
      step();
      rst = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cyclic_replay_queue.md
Name: cyclic_replay_queue

Overview:
Parametrised successor of the single-width cyclic queue used to feed the convolution engine with weights and line data. Stores up to DEPTH words. Operates in two run-time modes:
- consume: ordinary FIFO pop.
- cyclic: non-destructive replay that wraps over the stored entries indefinitely.
Adds occupancy flags, a wrap/loop indication for the accelerator controller, synchronous flush and sticky error reporting.

Parameters:
- DATA_W, 32, word width in bits.
- DEPTH, 64, storage entries; power of two, at least 2.
- LOOP_W, 8, width of the replay loop counter.
- Derived: AW = $clog2(DEPTH); count is AW+1 bits.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; has priority over wr_en and rd_en.
- cyclic  in  1  mode select: 1 = cyclic replay, 0 = consume (FIFO).
- wr_en  in  1  write request.
- data_in  in  DATA_W  write data.
- rd_en  in  1  read request.
- data_out  out  DATA_W  registered read data.
- data_valid  out  1  data_out updated by an accepted read this cycle.
- wrap  out  1  cyclic mode only: asserted with the last stored entry of a pass.
- loop_cnt  out  LOOP_W  completed replay passes, modulo 2^LOOP_W.
- count  out  AW+1  stored entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (rst=0, async): head, tail, idx, count and loop_cnt = 0; data_out = 0; data_valid, wrap, err = 0; empty = 1, full = 0. Memory contents are don't-care.
- clear=1 at a clock edge: same effect as reset on all pointers, counters and outputs. wr_en and rd_en are ignored that cycle.
- Write: accepted when wr_en=1 and not full. mem[tail] <= data_in, tail++ (wraps mod DEPTH), count++.
- Write when full: dropped, err <= 1. Exception: in consume mode with a simultaneous accepted read, the write is accepted.
- Read latency: 1 cycle. data_out and data_valid are updated on the edge after rd_en is sampled; data_out holds its value when no read is accepted.
- Consume read (cyclic=0, not empty): data_out <= mem[head], head++, count--.
- Simultaneous write and consume read: count is unchanged. Allowed at both full and empty boundaries? No: a read on empty is rejected even with a write present, and the write is still accepted.
- Cyclic read (cyclic=1, not empty): data_out <= mem[(head+idx) mod DEPTH]. head and count are unchanged.
  - If idx == count-1 (count sampled before any same-cycle write): idx <= 0, wrap <= 1, loop_cnt++.
  - Otherwise: idx++.
  - A same-cycle write extends the next pass, not the current one.
- Read when empty (either mode): rejected; data_valid=0, err <= 1, no pointer change.
- Whenever cyclic=0, idx is forced to 0. Consequences:
  - Switching to consume mode mid-replay pops from head.
  - Switching back to cyclic mode restarts the replay at head.
  - loop_cnt is kept across mode changes.
- wrap and data_valid are single-cycle pulses.
- full, empty and count are combinational from the count register.

Decomposition:
- Package cyclic_queue_pkg holds the mode constants (MODE_CONSUME = 1'b0, MODE_CYCLIC = 1'b1) and the default DATA_W/DEPTH localparams shared with the accelerator controller.
- Sub-module cyclic_queue_ram: DEPTH x DATA_W storage, synchronous write port, registered read port. It is the natural home for a later BRAM mapping.
- Pointer/mode control stays in the top level.

Test Plan:
- Reset: hold rst=0 with random wr_en/rd_en -> empty=1, full=0, count=0, data_out=0, data_valid=0, err=0. Release rst -> all values unchanged until the first request.
- Cyclic replay:
  - Stimulus: write 12 words 0xA0..0xAB, set cyclic=1, hold rd_en for 30 cycles.
  - Response: data_out sequence 0xA0..0xAB, 0xA0..0xAB, 0xA0..0xA5. wrap is high alongside both 0xAB outputs; loop_cnt = 2; count stays 12.
- Consume and underflow:
  - Stimulus: cyclic=0, write 0x1,0x2,0x3, then 4 reads.
  - Response: outputs 0x1,0x2,0x3 with data_valid; 4th read gives data_valid=0 and data_out stays 0x3; err=1, empty=1.
- Full boundary:
  - Stimulus: write 64 words; write 65th; then a simultaneous wr+rd in consume mode.
  - Response: full=1; the 65th write is dropped and err=1. The simultaneous wr+rd pops entry 0, accepts the new word, and count stays 64.
- Mode switch mid-replay:
  - Stimulus: 12 entries, cyclic read 5 times (0xA0..0xA4), set cyclic=0, read once, set cyclic=1, read once.
  - Response: the consume read returns 0xA0 and count=11; the next cyclic read returns 0xA1.
- Clear and reset mid-operation:
  - Stimulus: clear=1 together with wr_en=1 during replay.
  - Response: next cycle count=0, loop_cnt=0, err=0, data_out=0, and the write is ignored.
  - Also: asserting rst between clock edges clears outputs immediately, without waiting for an edge.
